// File: rtl/flash_spi_arb.sv
// flash_spi_arb
//   Shares one byte-level SPI master between the flash write engine (wr_*)
//   and the flash read engine (rd_*). Ownership covers a whole transaction,
//   from the first request byte through finish, so chip-select framing is
//   never split between engines. Round-robin fairness on ties, an enforced
//   CS-high gap after every transaction, and a watchdog that force-releases
//   a stalled owner.
//
// Ports
//   clk, rst                   system clock, synchronous active-high reset
//   wr_req/wr_din/wr_finish    write engine byte request, byte, end-of-transaction
//   wr_done/wr_dout/wr_gnt     byte-done, received byte, ownership to write engine
//   rd_*                       same set for the read engine
//   spi_req/spi_din/spi_finish registered request, byte, finish to SPI master
//   spi_done/spi_dout          byte complete and received byte from SPI master
//   busy                       arbiter not idle
//   timeout_err                one-cycle pulse on watchdog release
//   ovf_err                    one-cycle pulse when a pending byte is overwritten
module flash_spi_arb #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_din,
  input  logic       wr_finish,
  output logic       wr_done,
  output logic [7:0] wr_dout,
  output logic       wr_gnt,
  input  logic       rd_req,
  input  logic [7:0] rd_din,
  input  logic       rd_finish,
  output logic       rd_done,
  output logic [7:0] rd_dout,
  output logic       rd_gnt,
  output logic       spi_req,
  output logic [7:0] spi_din,
  output logic       spi_finish,
  input  logic       spi_done,
  input  logic [7:0] spi_dout,
  output logic       busy,
  output logic       timeout_err,
  output logic       ovf_err
);

  localparam int unsigned WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_W = 2'd1,
    OWN_R = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_rd_q, last_rd_d;     // 1: read engine served last
  logic             pend_w_q, pend_w_d;
  logic [7:0]       pend_w_byte_q, pend_w_byte_d;
  logic             pend_r_q, pend_r_d;
  logic [7:0]       pend_r_byte_q, pend_r_byte_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             spi_req_q, spi_req_d;
  logic [7:0]       spi_din_q, spi_din_d;
  logic             spi_finish_q, spi_finish_d;
  logic             tmo_q, tmo_d;
  logic             ovf_q, ovf_d;

  // Combinational helpers
  logic             cand_w, cand_r;
  logic             grant_w, grant_r;
  logic             park_w, park_r;
  logic             own_rd, own_req, own_fin;
  logic [7:0]       own_din;
  logic [WD_W-1:0]  wd_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_rd_q     <= 1'b1;
      pend_w_q      <= 1'b0;
      pend_w_byte_q <= '0;
      pend_r_q      <= 1'b0;
      pend_r_byte_q <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
      spi_req_q     <= 1'b0;
      spi_din_q     <= '0;
      spi_finish_q  <= 1'b0;
      tmo_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_rd_q     <= last_rd_d;
      pend_w_q      <= pend_w_d;
      pend_w_byte_q <= pend_w_byte_d;
      pend_r_q      <= pend_r_d;
      pend_r_byte_q <= pend_r_byte_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
      spi_req_q     <= spi_req_d;
      spi_din_q     <= spi_din_d;
      spi_finish_q  <= spi_finish_d;
      tmo_q         <= tmo_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_rd_d     = last_rd_q;
    pend_w_d      = pend_w_q;
    pend_w_byte_d = pend_w_byte_q;
    pend_r_d      = pend_r_q;
    pend_r_byte_d = pend_r_byte_q;
    wd_d          = wd_q;
    gap_d         = gap_q;
    spi_req_d     = 1'b0;
    spi_din_d     = spi_din_q;
    spi_finish_d  = 1'b0;
    tmo_d         = 1'b0;
    ovf_d         = 1'b0;
    grant_w       = 1'b0;
    grant_r       = 1'b0;
    park_w        = 1'b0;
    park_r        = 1'b0;

    cand_w  = wr_req | pend_w_q;
    cand_r  = rd_req | pend_r_q;
    own_rd  = (state_q == OWN_R);
    own_req = own_rd ? rd_req    : wr_req;
    own_fin = own_rd ? rd_finish : wr_finish;
    own_din = own_rd ? rd_din    : wr_din;
    wd_inc  = wd_q + WD_W'(1);

    unique case (state_q)
      IDLE: begin
        // On a tie the engine not served last wins.
        grant_w = cand_w & (~cand_r | last_rd_q);
        grant_r = cand_r & ~grant_w;
        if (grant_w) begin
          state_d   = OWN_W;
          last_rd_d = 1'b0;
          spi_req_d = 1'b1;
          spi_din_d = wr_req ? wr_din : pend_w_byte_q;
          pend_w_d  = 1'b0;
          wd_d      = '0;
        end else if (grant_r) begin
          state_d   = OWN_R;
          last_rd_d = 1'b1;
          spi_req_d = 1'b1;
          spi_din_d = rd_req ? rd_din : pend_r_byte_q;
          pend_r_d  = 1'b0;
          wd_d      = '0;
        end
        park_w = wr_req & ~grant_w;
        park_r = rd_req & ~grant_r;
      end

      OWN_W, OWN_R: begin
        // The non-owner always parks; the owner parks only a request that
        // coincides with its own finish (it opens a later transaction).
        park_w = wr_req & (own_rd | own_fin);
        park_r = rd_req & (~own_rd | own_fin);
        if (own_fin) begin
          spi_finish_d = 1'b1;
          state_d      = GAP;
          gap_d        = '0;
          wd_d         = '0;
        end else if (own_req) begin
          spi_req_d = 1'b1;
          spi_din_d = own_din;
          wd_d      = '0;
        end else if (spi_done) begin
          wd_d = '0;
        end else if (wd_inc == WD_LAST) begin
          // Decided the cycle the count reaches TIMEOUT_CYC-1 so the
          // registered finish lands TIMEOUT_CYC cycles after last activity.
          spi_finish_d = 1'b1;
          tmo_d        = 1'b1;
          state_d      = GAP;
          gap_d        = '0;
          wd_d         = '0;
        end else begin
          wd_d = wd_inc;
        end
      end

      GAP: begin
        park_w = wr_req;
        park_r = rd_req;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (park_w) begin
      if (pend_w_q) begin
        ovf_d = 1'b1;
      end
      pend_w_d      = 1'b1;
      pend_w_byte_d = wr_din;
    end
    if (park_r) begin
      if (pend_r_q) begin
        ovf_d = 1'b1;
      end
      pend_r_d      = 1'b1;
      pend_r_byte_d = rd_din;
    end
  end

  // Zero-latency return path keyed on the registered owner.
  always_comb begin
    wr_done = 1'b0;
    wr_dout = '0;
    rd_done = 1'b0;
    rd_dout = '0;
    if (state_q == OWN_W) begin
      wr_done = spi_done;
      wr_dout = spi_dout;
    end else if (state_q == OWN_R) begin
      rd_done = spi_done;
      rd_dout = spi_dout;
    end
  end

  assign wr_gnt      = (state_q == OWN_W);
  assign rd_gnt      = (state_q == OWN_R);
  assign busy        = (state_q != IDLE);
  assign spi_req     = spi_req_q;
  assign spi_din     = spi_din_q;
  assign spi_finish  = spi_finish_q;
  assign timeout_err = tmo_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_flash_spi_arb.sv
// Directed bench for flash_spi_arb: single write, tie fairness, non-owner
// parking, pending overwrite, watchdog release and mid-transaction reset.
module tb_flash_spi_arb;
  localparam int unsigned TMO   = 20;
  localparam int unsigned GAP_C = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, wr_finish, wr_done, wr_gnt;
  logic [7:0] wr_din, wr_dout;
  logic       rd_req, rd_finish, rd_done, rd_gnt;
  logic [7:0] rd_din, rd_dout;
  logic       spi_req, spi_finish, spi_done;
  logic [7:0] spi_din, spi_dout;
  logic       busy, timeout_err, ovf_err;

  int n_pass  = 0;
  int n_total = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  flash_spi_arb #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP_C)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_din(wr_din), .wr_finish(wr_finish),
    .wr_done(wr_done), .wr_dout(wr_dout), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_din(rd_din), .rd_finish(rd_finish),
    .rd_done(rd_done), .rd_dout(rd_dout), .rd_gnt(rd_gnt),
    .spi_req(spi_req), .spi_din(spi_din), .spi_finish(spi_finish),
    .spi_done(spi_done), .spi_dout(spi_dout),
    .busy(busy), .timeout_err(timeout_err), .ovf_err(ovf_err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_o();
    tick();
    ovf_cnt += int'(ovf_err);
  endtask

  task automatic clear_inputs();
    wr_req = 1'b0; wr_finish = 1'b0; rd_req = 1'b0; rd_finish = 1'b0;
    spi_done = 1'b0; wr_din = '0; rd_din = '0; spi_dout = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    spi_done = 1'b1; spi_dout = 8'hFF;
    tick(); tick();
    #1;
    n_total++; if ({spi_req, spi_finish, wr_gnt, rd_gnt, busy, timeout_err, ovf_err, wr_done, rd_done} !== 9'b0)
      $display("FAIL reset_ctrl got=%b exp=000000000", {spi_req, spi_finish, wr_gnt, rd_gnt, busy, timeout_err, ovf_err, wr_done, rd_done}); else n_pass++;
    n_total++; if ({spi_din, wr_dout, rd_dout} !== 24'h0)
      $display("FAIL reset_data got=%h exp=000000", {spi_din, wr_dout, rd_dout}); else n_pass++;
    rst = 1'b0; spi_done = 1'b0; spi_dout = '0;
    tick();
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_din = 8'h06;
    tick();
    wr_req = 1'b0;
    n_total++; if (spi_req !== 1'b1) $display("FAIL sw_spi_req got=%b exp=1", spi_req); else n_pass++;
    n_total++; if (spi_din !== 8'h06) $display("FAIL sw_spi_din got=%h exp=06", spi_din); else n_pass++;
    n_total++; if ({wr_gnt, rd_gnt, busy} !== 3'b101) $display("FAIL sw_gnt got=%b exp=101", {wr_gnt, rd_gnt, busy}); else n_pass++;
    tick();
    n_total++; if (spi_req !== 1'b0) $display("FAIL sw_req_pulse got=%b exp=0", spi_req); else n_pass++;
    spi_done = 1'b1; spi_dout = 8'hA5;
    #1;
    n_total++; if ({wr_done, wr_dout} !== {1'b1, 8'hA5}) $display("FAIL sw_done got=%b/%h exp=1/a5", wr_done, wr_dout); else n_pass++;
    n_total++; if ({rd_done, rd_dout} !== 9'h0) $display("FAIL sw_rd_quiet got=%b/%h exp=0/00", rd_done, rd_dout); else n_pass++;
    tick();
    spi_done = 1'b0; spi_dout = '0;
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
    n_total++; if ({spi_finish, wr_gnt, busy} !== 3'b101) $display("FAIL sw_finish got=%b exp=101", {spi_finish, wr_gnt, busy}); else n_pass++;
    tick();
    n_total++; if ({spi_finish, busy} !== 2'b01) $display("FAIL sw_gap2 got=%b exp=01", {spi_finish, busy}); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL sw_idle got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_tie();
    reset_dut();
    wr_req = 1'b1; wr_din = 8'h11; rd_req = 1'b1; rd_din = 8'h22;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    n_total++; if ({spi_req, spi_din, wr_gnt, rd_gnt} !== {1'b1, 8'h11, 2'b10}) $display("FAIL tie1 got=%b/%h/%b%b exp=1/11/10", spi_req, spi_din, wr_gnt, rd_gnt); else n_pass++;
    tick();
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
    n_total++; if ({spi_finish, rd_gnt} !== 2'b10) $display("FAIL tie_fin got=%b exp=10", {spi_finish, rd_gnt}); else n_pass++;
    tick();
    n_total++; if ({spi_req, rd_gnt} !== 2'b00) $display("FAIL tie_gap got=%b exp=00", {spi_req, rd_gnt}); else n_pass++;
    tick();
    // IDLE cycle: pending read ties with a fresh write; write was served last.
    wr_req = 1'b1; wr_din = 8'h33;
    tick();
    wr_req = 1'b0;
    n_total++; if ({spi_req, spi_din, wr_gnt, rd_gnt} !== {1'b1, 8'h22, 2'b01}) $display("FAIL tie2 got=%b/%h/%b%b exp=1/22/01", spi_req, spi_din, wr_gnt, rd_gnt); else n_pass++;
    rd_finish = 1'b1;
    tick();
    rd_finish = 1'b0;
    tick(); tick(); tick();
    n_total++; if ({spi_req, spi_din, wr_gnt} !== {1'b1, 8'h33, 1'b1}) $display("FAIL tie_wr_pend got=%b/%h/%b exp=1/33/1", spi_req, spi_din, wr_gnt); else n_pass++;
    wr_finish = 1'b1;
    tick();
    wr_finish = 1'b0;
    tick(); tick();
  endtask

  task automatic test_nonowner();
    logic [7:0] b;
    for (int k = 0; k < 5; k++) begin
      b = 8'hA0 + 8'(k);
      wr_req = 1'b1; wr_din = b;
      tick();
      wr_req = 1'b0;
      n_total++; if ({spi_req, spi_din} !== {1'b1, b}) $display("FAIL no_byte%0d got=%b/%h exp=1/%h", k, spi_req, spi_din, b); else n_pass++;
      spi_done = 1'b1; spi_dout = 8'h50 + 8'(k);
      if (k == 1) begin
        rd_req = 1'b1; rd_din = 8'h9F;
      end
      #1;
      n_total++; if ({wr_done, rd_done, wr_gnt, rd_gnt, rd_dout} !== {4'b1010, 8'h00}) $display("FAIL no_route%0d got=%b%b%b%b/%h exp=1010/00", k, wr_done, rd_done, wr_gnt, rd_gnt, rd_dout); else n_pass++;
      tick();
      spi_done = 1'b0; rd_req = 1'b0;
    end
    wr_finish = 1'b1; rd_finish = 1'b1;
    tick();
    wr_finish = 1'b0; rd_finish = 1'b0;
    n_total++; if ({spi_finish, rd_gnt, spi_req} !== 3'b100) $display("FAIL no_fin got=%b exp=100", {spi_finish, rd_gnt, spi_req}); else n_pass++;
    tick();
    n_total++; if (spi_req !== 1'b0) $display("FAIL no_gap got=%b exp=0", spi_req); else n_pass++;
    tick(); tick();
    n_total++; if ({spi_req, spi_din, rd_gnt} !== {1'b1, 8'h9F, 1'b1}) $display("FAIL no_9f got=%b/%h/%b exp=1/9f/1", spi_req, spi_din, rd_gnt); else n_pass++;
    rd_finish = 1'b1;
    tick();
    rd_finish = 1'b0;
    tick(); tick();
  endtask

  task automatic test_overflow();
    ovf_cnt = 0;
    wr_req = 1'b1; wr_din = 8'h01;
    tick_o();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_din = 8'h03;
    tick_o();
    rd_req = 1'b0;
    tick_o();
    rd_req = 1'b1; rd_din = 8'h0B;
    tick_o();
    rd_req = 1'b0;
    n_total++; if (ovf_err !== 1'b1) $display("FAIL ovf_pulse got=%b exp=1", ovf_err); else n_pass++;
    wr_finish = 1'b1;
    tick_o();
    wr_finish = 1'b0;
    tick_o(); tick_o(); tick_o();
    n_total++; if ({spi_req, spi_din, rd_gnt} !== {1'b1, 8'h0B, 1'b1}) $display("FAIL ovf_byte got=%b/%h/%b exp=1/0b/1", spi_req, spi_din, rd_gnt); else n_pass++;
    rd_finish = 1'b1;
    tick_o();
    rd_finish = 1'b0;
    tick_o(); tick_o();
    n_total++; if (ovf_cnt !== 1) $display("FAIL ovf_count got=%0d exp=1", ovf_cnt); else n_pass++;
  endtask

  task automatic test_watchdog();
    logic early;
    early = 1'b0;
    wr_req = 1'b1; wr_din = 8'h05;
    tick();
    wr_req = 1'b0;
    tick();
    spi_done = 1'b1; spi_dout = 8'h12;
    tick();
    spi_done = 1'b0;
    for (int i = 1; i < int'(TMO); i++) begin
      if (spi_finish || timeout_err || !wr_gnt) early = 1'b1;
      tick();
    end
    n_total++; if (early !== 1'b0) $display("FAIL wd_early got=%b exp=0", early); else n_pass++;
    n_total++; if ({spi_finish, timeout_err, wr_gnt, busy} !== 4'b1101) $display("FAIL wd_fire got=%b exp=1101", {spi_finish, timeout_err, wr_gnt, busy}); else n_pass++;
    tick();
    n_total++; if ({spi_finish, timeout_err, busy} !== 3'b001) $display("FAIL wd_pulse got=%b exp=001", {spi_finish, timeout_err, busy}); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL wd_idle got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic stray;
    stray = 1'b0;
    rd_req = 1'b1; rd_din = 8'h77;
    tick();
    rd_req = 1'b0;
    n_total++; if (rd_gnt !== 1'b1) $display("FAIL rm_own got=%b exp=1", rd_gnt); else n_pass++;
    wr_req = 1'b1; wr_din = 8'h88;
    tick();
    wr_req = 1'b0;
    rst = 1'b1; rd_req = 1'b1; rd_din = 8'h66; spi_done = 1'b1; spi_dout = 8'hCC;
    tick();
    n_total++; if ({spi_req, spi_finish, wr_gnt, rd_gnt, busy, timeout_err, ovf_err, wr_done, rd_done} !== 9'b0)
      $display("FAIL rm_ctrl got=%b exp=000000000", {spi_req, spi_finish, wr_gnt, rd_gnt, busy, timeout_err, ovf_err, wr_done, rd_done}); else n_pass++;
    n_total++; if ({spi_din, wr_dout, rd_dout} !== 24'h0) $display("FAIL rm_data got=%h exp=000000", {spi_din, wr_dout, rd_dout}); else n_pass++;
    rst = 1'b0; rd_req = 1'b0; spi_done = 1'b0; spi_dout = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (spi_req || busy || wr_gnt) stray = 1'b1;
    end
    n_total++; if (stray !== 1'b0) $display("FAIL rm_pend_dropped got=%b exp=0", stray); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_nonowner();
    test_overflow();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout_guard got=running exp=finished");
    $fatal(1);
  end

endmodule
